// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, prefetches the word at PC into a one-entry buffer, loads IR on ir_write.
// Latency: data usable the cycle after imem_valid; an ir_write coinciding with imem_valid in REQ bypasses into IR.
// Backpressure: stall rises while ir_write waits on an empty buffer; requests are never aborted once issued.
// Ports: clk/rst (async active-low), clk_en gates ir_write/pc_write, pc_next is the new PC from the ALU,
//        imem_req/imem_addr/imem_rdata/imem_valid form the memory handshake,
//        pc/instr plus decoded fields go to the controller/datapath, misaligned is sticky until reset.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        ir_write,
   input  logic        pc_write,
   input  logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   output logic        stall,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic        misaligned
);

   typedef enum logic [1:0] {REQ, WAIT_DISCARD, FULL} state_t;

   state_t      state;
   logic [31:0] fetch_buf;
   logic [31:0] req_addr;    // address of a request that pc has already moved past
   logic        accept_ir;
   logic        accept_pc;
   logic        bypass;

   assign accept_ir = clk_en & ir_write;
   assign accept_pc = clk_en & pc_write;
   // Data arriving for the current pc while the buffer is empty can feed IR directly.
   assign bypass    = (state == REQ) & imem_valid;

   // Gated by rst so the request drops the instant reset asserts, without waiting for an edge.
   assign imem_req  = rst & (state != FULL);
   assign imem_addr = (state == WAIT_DISCARD) ? req_addr : pc;
   assign stall     = rst & accept_ir & (state != FULL) & ~bypass;

   assign opcode = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign shamt  = instr[10:6];
   assign funct  = instr[5:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= REQ;
         pc         <= RESET_PC;
         instr      <= 32'h0;
         fetch_buf  <= 32'h0;
         req_addr   <= RESET_PC;
         misaligned <= 1'b0;
      end else begin
         if (accept_pc) begin
            pc <= {pc_next[31:2], 2'b00};
            if (pc_next[1:0] != 2'b00) begin
               misaligned <= 1'b1;
            end
         end

         case (state)
            REQ: begin
               if (imem_valid) begin
                  fetch_buf <= imem_rdata;
                  if (accept_ir) begin
                     instr <= imem_rdata;
                  end
                  // A simultaneous pc change makes the captured word stale for the new pc.
                  state <= accept_pc ? REQ : FULL;
               end else if (accept_pc) begin
                  // Keep presenting the old address until memory answers it.
                  req_addr <= pc;
                  state    <= WAIT_DISCARD;
               end
            end
            WAIT_DISCARD: begin
               if (imem_valid) begin
                  state <= REQ;
               end
            end
            FULL: begin
               if (accept_ir) begin
                  instr <= fetch_buf;
               end
               if (accept_pc) begin
                  state <= REQ;
               end
            end
            default: state <= REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        clk_en;
   logic        ir_write;
   logic        pc_write;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        stall;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic        misaligned;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .ir_write(ir_write), .pc_write(pc_write),
      .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_valid(imem_valid), .stall(stall), .pc(pc), .instr(instr), .opcode(opcode),
      .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .misaligned(misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        irw;
      logic        pcw;
      logic [31:0] pcn;
      logic        vld;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_stall;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_mis;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic en, input logic irw, input logic pcw, input logic [31:0] pcn,
                      input logic vld, input logic [31:0] rdata,
                      input logic e_req, input logic [31:0] e_addr, input logic e_stall,
                      input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_mis);
      vec_t v;
      v.en = en; v.irw = irw; v.pcw = pcw; v.pcn = pcn; v.vld = vld; v.rdata = rdata;
      v.e_req = e_req; v.e_addr = e_addr; v.e_stall = e_stall;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_mis = e_mis;
      vecs.push_back(v);
   endtask

   initial begin
      clk_en = 1'b1; ir_write = 1'b0; pc_write = 1'b0; pc_next = 32'h0;
      imem_valid = 1'b0; imem_rdata = 32'h0; rst = 1'b0;

      //   en irw pcw pc_next       vld rdata          req addr          stall pc            instr          mis
      // fetch at 0, two-cycle memory, then normal fetch cycle (IR + PC together)
      add(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 0); // 0
      add(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 0); // 1
      add(1, 0, 0, 32'h0,        1, 32'h0109_5020,1, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 0); // 2
      add(1, 1, 1, 32'h4,        0, 32'h0,        0, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 0); // 3
      // ir_write on an empty buffer, latency 3: two stall cycles then bypass
      add(1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 1, 32'h0000_0004, 32'h0109_5020, 0); // 4
      add(1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 1, 32'h0000_0004, 32'h0109_5020, 0); // 5
      add(1, 1, 0, 32'h0,        1, 32'h8C0A_0004,1, 32'h0000_0004, 0, 32'h0000_0004, 32'h0109_5020, 0); // 6
      add(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0004, 0, 32'h0000_0004, 32'h8C0A_0004, 0); // 7
      // pc moves to 0x40 while the request to 4 is outstanding
      add(1, 0, 1, 32'h4,        0, 32'h0,        0, 32'h0000_0004, 0, 32'h0000_0004, 32'h8C0A_0004, 0); // 8
      add(1, 0, 1, 32'h40,       0, 32'h0,        1, 32'h0000_0004, 0, 32'h0000_0004, 32'h8C0A_0004, 0); // 9
      add(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 0, 32'h0000_0040, 32'h8C0A_0004, 0); // 10
      add(1, 0, 0, 32'h0,        1, 32'hDEAD_BEEF,1, 32'h0000_0004, 0, 32'h0000_0040, 32'h8C0A_0004, 0); // 11
      add(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0040, 0, 32'h0000_0040, 32'h8C0A_0004, 0); // 12
      add(1, 0, 0, 32'h0,        1, 32'hAC0B_0008,1, 32'h0000_0040, 0, 32'h0000_0040, 32'h8C0A_0004, 0); // 13
      add(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0040, 0, 32'h0000_0040, 32'h8C0A_0004, 0); // 14
      // clk_en low: writes ignored, fetch still completes
      add(1, 0, 1, 32'h44,       0, 32'h0,        0, 32'h0000_0040, 0, 32'h0000_0040, 32'hAC0B_0008, 0); // 15
      add(0, 1, 1, 32'h80,       0, 32'h0,        1, 32'h0000_0044, 0, 32'h0000_0044, 32'hAC0B_0008, 0); // 16
      add(0, 1, 1, 32'h80,       1, 32'h1111_1111,1, 32'h0000_0044, 0, 32'h0000_0044, 32'hAC0B_0008, 0); // 17
      add(0, 1, 1, 32'h80,       0, 32'h0,        0, 32'h0000_0044, 0, 32'h0000_0044, 32'hAC0B_0008, 0); // 18
      // misaligned target, then stickiness through later writes
      add(1, 1, 1, 32'h12,       0, 32'h0,        0, 32'h0000_0044, 0, 32'h0000_0044, 32'hAC0B_0008, 0); // 19
      add(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0010, 0, 32'h0000_0010, 32'h1111_1111, 1); // 20
      add(1, 0, 0, 32'h0,        1, 32'h2222_2222,1, 32'h0000_0010, 0, 32'h0000_0010, 32'h1111_1111, 1); // 21
      add(1, 1, 1, 32'h14,       0, 32'h0,        0, 32'h0000_0010, 0, 32'h0000_0010, 32'h1111_1111, 1); // 22
      // bypass with simultaneous pc_write in REQ: IR gets old-pc word, new fetch at 0x40
      add(1, 1, 1, 32'h40,       1, 32'h3333_3333,1, 32'h0000_0014, 0, 32'h0000_0014, 32'h2222_2222, 1); // 23
      add(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0040, 0, 32'h0000_0040, 32'h3333_3333, 1); // 24

      // reset state, with ir_write high to show stall is held low during reset
      repeat (2) @(negedge clk);
      ir_write = 1'b1;
      #1;
      chk("reset imem_req", {31'b0, imem_req}, 32'd0);
      chk("reset stall", {31'b0, stall}, 32'd0);
      chk("reset pc", pc, 32'h0);
      chk("reset instr", instr, 32'h0);
      chk("reset fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);
      chk("reset misaligned", {31'b0, misaligned}, 32'd0);

      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         if (i != 0) @(negedge clk);
         clk_en = vecs[i].en; ir_write = vecs[i].irw; pc_write = vecs[i].pcw;
         pc_next = vecs[i].pcn; imem_valid = vecs[i].vld; imem_rdata = vecs[i].rdata;
         #1;
         chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
         if (vecs[i].e_req) chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
         chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
         chk($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
         chk($sformatf("v%0d fields", i), {opcode, rs, rt, rd, shamt, funct},
             {vecs[i].e_instr[31:26], vecs[i].e_instr[25:21], vecs[i].e_instr[20:16],
              vecs[i].e_instr[15:11], vecs[i].e_instr[10:6], vecs[i].e_instr[5:0]});
         chk($sformatf("v%0d misaligned", i), {31'b0, misaligned}, {31'b0, vecs[i].e_mis});
         if (i == 4) begin
            // add $t2,$t0,$t1 decoded
            chk("add opcode", {26'b0, opcode}, 32'd0);
            chk("add funct", {26'b0, funct}, 32'h20);
            chk("add rd", {27'b0, rd}, 32'd10);
         end
      end

      // reset pulse while the request to 0x40 is outstanding
      @(negedge clk);
      clk_en = 1'b1; ir_write = 1'b1; pc_write = 1'b0; imem_valid = 1'b0; rst = 1'b0;
      #1;
      chk("rst mid-req imem_req", {31'b0, imem_req}, 32'd0);
      chk("rst mid-req stall", {31'b0, stall}, 32'd0);
      chk("rst mid-req pc", pc, 32'h0);
      chk("rst mid-req instr", instr, 32'h0);
      chk("rst mid-req misaligned", {31'b0, misaligned}, 32'd0);
      @(negedge clk);
      ir_write = 1'b0;
      rst = 1'b1;
      #1;
      chk("post-rst imem_req", {31'b0, imem_req}, 32'd1);
      chk("post-rst imem_addr", imem_addr, 32'h0);
      @(negedge clk);
      imem_valid = 1'b1; imem_rdata = 32'h2402_0005;
      @(negedge clk);
      imem_valid = 1'b0; ir_write = 1'b1;
      #1;
      chk("post-rst full imem_req", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
      ir_write = 1'b0;
      #1;
      chk("post-rst instr", instr, 32'h2402_0005);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multicycle controller.
- Owns the PC, runs a req/valid handshake with instruction memory and prefetches the word at the current PC into a fetch buffer.
- Loads that word into the instruction register when the controller asserts IRWrite; presents opcode/funct and register fields to the controller and datapath.
- Takes the new PC from the datapath ALU result when the controller asserts PCWrite.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset (0 = reset)
clk_en  input  1  global clock enable; ir_write/pc_write take effect only when high
ir_write  input  1  controller IRWrite
pc_write  input  1  controller PCWrite
pc_next  input  32  new PC (ALU result)
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address
imem_rdata  input  32  fetched word
imem_valid  input  1  imem_rdata valid this cycle (completes request)
stall  output  1  ir_write requested but fetch buffer empty
pc  output  32  current PC
instr  output  32  instruction register
opcode  output  6  instr[31:26]
rs  output  5  instr[25:21]
rt  output  5  instr[20:16]
rd  output  5  instr[15:11]
shamt  output  5  instr[10:6]
funct  output  6  instr[5:0]
misaligned  output  1  sticky: pc_next[1:0]!=0 accepted

Behaviour:
- Reset (rst low, async): pc=RESET_PC, instr=0, buffer empty, misaligned=0, FSM=REQ. Outputs imem_req=0 and stall=0 while rst low. All fields derive from instr, so they reset to 0.
- FSM states:
  - REQ: imem_req=1, imem_addr=pc.
  - WAIT_DISCARD: imem_req=1, imem_addr=latched old address.
  - FULL: imem_req=0, buffer valid.
- REQ:
  - imem_valid=1 -> capture imem_rdata into buffer, go to FULL. Earliest data use is the cycle after imem_valid.
  - An accepted pc_write while in REQ with imem_valid=0 -> pc updates and FSM goes to WAIT_DISCARD. The request is never aborted: imem_addr holds the old address until imem_valid.
- WAIT_DISCARD: on imem_valid the data is dropped and FSM goes to REQ with the new pc. Further pc_writes here update pc only.
- FULL:
  - accepted ir_write: instr <= buffer.
  - accepted pc_write: pc <= pc_next, buffer invalidated, FSM -> REQ. The next request starts the following cycle at the new pc.
- Simultaneous ir_write and pc_write in FULL (normal fetch cycle): IR gets the word fetched at the old pc, pc takes pc_next, FSM -> REQ. Both happen on the same edge.
- ir_write accepted while buffer empty (REQ/WAIT_DISCARD):
  - stall=1 combinationally; instr unchanged.
  - If imem_valid=1 in REQ that same cycle, bypass: instr <= imem_rdata and stall=0.
- The controller must hold its state while stall=1. pc_write in a stalled cycle is still accepted.
- clk_en=0: ir_write/pc_write ignored. The memory handshake still completes (captures continue) so that memory is not stranded.
- imem_addr and imem_req are stable while a request is outstanding.
- pc_next with low bits nonzero: pc takes pc_next with [1:0] forced to 00; misaligned set until reset.
- Reset mid-request: request dropped immediately (imem_req=0). After reset, a fresh request is issued at RESET_PC. The memory model must tolerate the abandoned request.
- pc arithmetic is external; the block never increments pc itself.

Test Plan:
1. Reset release, memory returns 32'h0109_5020 (add $t2,$t0,$t1) 2 cycles after req -> imem_addr=0, FULL; ir_write+pc_write (pc_next=4) -> instr=32'h0109_5020, opcode=0, funct=6'h20, rd=10, pc=4, new req addr 4.
2. ir_write asserted in REQ, memory latency 3 -> stall=1 for 2 cycles, instr unchanged; on the imem_valid cycle stall=0 and instr=imem_rdata (bypass).
3. pc_write pc_next=32'h40 while req to 4 outstanding -> imem_addr stays 4 until valid, that data dropped, next req addr 32'h40, buffer holds word at 32'h40.
4. clk_en=0 with ir_write=pc_write=1 for 3 cycles -> pc, instr unchanged; fetch still completes into FULL.
5. pc_next=32'h0000_0012 -> pc=32'h10, misaligned=1 and stays 1 through later writes until rst low.
6. rst pulsed low during an outstanding request at pc=32'h40 -> imem_req drops asynchronously, pc=RESET_PC, instr=0; after release req addr=RESET_PC.
